// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);
  localparam logic        LINE_IDLE  = 1'b1;
  localparam logic        LINE_START = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  // Serial line level for a given state; only DATA depends on the payload.
  function automatic logic line_level(input tx_state_e state, input logic data_bit);
    case (state)
      ST_START: return LINE_START;
      ST_DATA:  return data_bit;
      default:  return LINE_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud-rate counter: bit_tick_o marks the last clock of each CLKS_PER_BIT-long bit.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic bit_tick_o
);

  localparam int unsigned          CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]     LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_tick_o = (cnt_q == LAST);

  // Restart wins so every new state begins its first bit at count zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || bit_tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Reads bytes from the read side of an async FIFO and shifts them out as 8N1/8N2 UART frames.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  input  logic                 tx_en,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 byte_done
);

  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);
  localparam logic                 STOP_LAST = (STOP_BITS == 2);

  tx_state_e              state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic                   stop_idx_q, stop_idx_d;
  logic                   uart_tx_q, uart_tx_d;
  logic                   armed_q;
  logic                   bit_tick;
  logic                   timer_restart;
  logic                   can_fetch;

  // armed_q delays the first fetch after reset release by one edge.
  assign can_fetch     = tx_en && !fifo_empty && armed_q;
  assign timer_restart = (state_d != state_q);

  uart_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_bit_timer (
    .clk        (rd_clk),
    .rst_n      (rd_rst_n),
    .restart_i  (timer_restart),
    .bit_tick_o (bit_tick)
  );

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_idx_d = stop_idx_q;
    byte_done  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (can_fetch) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d = fifo_rd_data;
        state_d = ST_START;
      end
      ST_START: begin
        if (bit_tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_BIT) begin
            stop_idx_d = 1'b0;
            state_d    = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_idx_q == STOP_LAST) begin
            byte_done = 1'b1;
            state_d   = can_fetch ? ST_FETCH : ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The pin register is loaded from next-state so it lines up with state_q.
    uart_tx_d = line_level(state_d, shift_d[0]);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      uart_tx_q  <= LINE_IDLE;
      armed_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      stop_idx_q <= stop_idx_d;
      uart_tx_q  <= uart_tx_d;
      armed_q    <= 1'b1;
    end
  end

  assign uart_tx    = uart_tx_q;
  assign fifo_rd_en = (state_q == ST_FETCH);
  assign tx_busy    = (state_q != ST_IDLE);

endmodule
